mem_access_unit: RTL and testbench

//  Initiator for the shared instruction/data memory (word-addressed, big-endian byte lanes: byte at word+0 = bits[31:24]).

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_lane_unit.sv | 57 +++++
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: funct3 width codes, FSM states, request legality.
// Pure declarations; no timing or flow-control content.
package mem_access_pkg;

    localparam int XLEN_DFLT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // High when the request must be rejected: illegal width code, unsigned store, or misalignment.
    function automatic logic req_bad(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = st;
            F3_HU:   bad = st | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Big-endian lane select: extracts/extends a load value and merges store data into a word.
// Purely combinational, zero latency; no flow control.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[31:24];
        case (off_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = word_i;
        endcase
    end

    // Full-word stores bypass the read word entirely.
    always_comb begin
        store_o = wdata_i;
        if (funct3_i == F3_B) begin
            store_o = word_i;
            case (off_i)
                2'd0:    store_o[31:24] = wdata_i[7:0];
                2'd1:    store_o[23:16] = wdata_i[7:0];
                2'd2:    store_o[15:8]  = wdata_i[7:0];
                default: store_o[7:0]   = wdata_i[7:0];
            endcase
        end else if (funct3_i == F3_H) begin
            store_o = word_i;
            if (off_i[1]) store_o[15:0]  = wdata_i[15:0];
            else          store_o[31:16] = wdata_i[15:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store initiator: word-aligned memory cycles, RMW for SB/SH, error on bad requests.
// Latency start->done: err 1, load/SW 2, SB/SH 3; start ignored while busy (no queueing).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rdata,
    output logic [31:0]     mem_adr,
    output logic [31:0]     mem_wd,
    output logic            mem_we,
    input  logic [31:0]     mem_rd
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            is_store_q, is_store_d;
    logic            err_q, err_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     lane_word, load_val, store_val;

    // In READ the live memory word feeds the lane unit so the load result lands with DONE.
    assign lane_word = (state_q == READ) ? mem_rd : word_q;

    mem_lane_unit u_lane (
        .word_i   (lane_word),
        .off_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_val),
        .store_o  (store_val)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    if (req_bad(is_store, funct3, addr[1:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (is_store && (funct3 == F3_W)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                word_d = mem_rd;
                if (is_store_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = DONE;
                    rdata_d = load_val;
                    err_d   = 1'b0;
                end
            end
            WRITE: begin
                state_d = DONE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            word_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign mem_adr = {addr_q[31:2], 2'b00};
    assign mem_wd  = store_val;
    // Reset during WRITE must suppress the memory update.
    assign mem_we  = (state_q == WRITE) && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed big-endian memory plus a byte-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_adr, mem_wd, mem_rd;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] exp_rdata = 32'h0;
    int          checks = 0, failures = 0;
    int          we_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always_comb mem_rd = {mem[{mem_adr[15:2], 2'b00}], mem[{mem_adr[15:2], 2'b01}],
                          mem[{mem_adr[15:2], 2'b10}], mem[{mem_adr[15:2], 2'b11}]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[{mem_adr[15:2], 2'b00}] <= mem_wd[31:24];
            mem[{mem_adr[15:2], 2'b01}] <= mem_wd[23:16];
            mem[{mem_adr[15:2], 2'b10}] <= mem_wd[15:8];
            mem[{mem_adr[15:2], 2'b11}] <= mem_wd[7:0];
            we_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) return 1'b1;
        if (st && f3[2]) return 1'b1;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a[15:0]);
        b = ref_mem[i];
        h = {ref_mem[i], ref_mem[i+1]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int i;
        i = int'(a[15:0]);
        case (f3[1:0])
            2'd0: ref_mem[i] = wd[7:0];
            2'd1: begin ref_mem[i] = wd[15:8]; ref_mem[i+1] = wd[7:0]; end
            default: begin
                ref_mem[i] = wd[31:24]; ref_mem[i+1] = wd[23:16];
                ref_mem[i+2] = wd[15:8]; ref_mem[i+3] = wd[7:0];
            end
        endcase
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int i;
        i = int'({a[15:2], 2'b00});
        return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int i;
        i = int'({a[15:2], 2'b00});
        return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    endfunction

    // One request end to end; with spam, start stays high (with junk fields) until done is seen.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit spam);
        logic bad;
        int   exp_lat, lat, we0, dn0;
        bad     = model_bad(st, f3, a);
        exp_lat = bad ? 1 : ((!st || f3 == 3'b010) ? 2 : 3);
        if (!bad && !st) exp_rdata = model_load(f3, a);
        if (!bad && st) model_store(f3, a, wd);
        we0 = we_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (spam) begin
                is_store = 1'($urandom); funct3 = 3'($urandom);
                addr = {16'h0, 16'($urandom)}; wdata = $urandom;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 8);
        start = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " err"}, {31'h0, err}, {31'h0, bad});
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " writes"}, we_cnt - we0, (st && !bad) ? 1 : 0);
        check({tag, " mem word"}, mem_word(a), ref_word(a));
        @(negedge clk);
        check({tag, " idle after done"}, {30'h0, busy, done}, 32'h0);
        repeat (2) @(negedge clk);
        check({tag, " done count"}, done_cnt - dn0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [2:0]  f3;
        logic [31:0] a;
        int          we0, dn0;
        logic [2:0]  legal [5];
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            mem[i] = b;
            ref_mem[i] = b;
        end
        mem[16'h100] = 8'h88; mem[16'h101] = 8'h99; mem[16'h102] = 8'hAA; mem[16'h103] = 8'hBB;
        ref_mem[16'h100] = 8'h88; ref_mem[16'h101] = 8'h99; ref_mem[16'h102] = 8'hAA; ref_mem[16'h103] = 8'hBB;

        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset flags", {28'h0, busy, done, err, mem_we}, 32'h0);
        check("reset rdata", rdata, 32'h0);

        do_req("LB 0x101", 1'b0, 3'b000, 32'h101, 32'h0, 1'b0);
        check("LB value", rdata, 32'hFFFFFF99);
        do_req("LBU 0x103", 1'b0, 3'b100, 32'h103, 32'h0, 1'b0);
        check("LBU value", rdata, 32'h000000BB);
        do_req("LHU 0x100", 1'b0, 3'b101, 32'h100, 32'h0, 1'b0);
        check("LHU value", rdata, 32'h00008899);
        do_req("LH 0x102", 1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
        check("LH value", rdata, 32'hFFFFAABB);
        do_req("LW 0x100", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        check("LW value", rdata, 32'h8899AABB);

        do_req("SB 0x102", 1'b1, 3'b000, 32'h102, 32'h12345655, 1'b0);
        check("SB word", mem_word(32'h100), 32'h889955BB);
        do_req("SH 0x100", 1'b1, 3'b001, 32'h100, 32'h0000CAFE, 1'b0);
        check("SH word", mem_word(32'h100), 32'hCAFE55BB);
        do_req("SW 0x104", 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0);
        check("SW word", mem_word(32'h104), 32'hDEADBEEF);

        do_req("SH 0x101 misaligned", 1'b1, 3'b001, 32'h101, 32'h1111, 1'b0);
        do_req("LW 0x102 misaligned", 1'b0, 3'b010, 32'h102, 32'h0, 1'b0);
        do_req("funct3 011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
        do_req("SBU illegal", 1'b1, 3'b100, 32'h100, 32'h0, 1'b0);
        check("rdata held over errors", rdata, 32'h8899AABB);

        // Reset lands in the WRITE cycle of an SB: no write, no done, outputs back to reset values.
        we0 = we_cnt; dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h100; wdata = 32'h77;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'h0;
        check("abort flags", {28'h0, busy, done, err, mem_we}, 32'h0);
        check("abort rdata", rdata, 32'h0);
        check("abort writes", we_cnt - we0, 0);
        check("abort done count", done_cnt - dn0, 0);
        check("abort word", mem_word(32'h100), 32'hCAFE55BB);
        do_req("LW after abort", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0);

        do_req("spam LW 0x104", 1'b0, 3'b010, 32'h104, 32'h0, 1'b1);
        do_req("spam SB 0x203", 1'b1, 3'b000, 32'h203, 32'hA5A5A5C3, 1'b1);

        for (int n = 0; n < 60; n++) begin
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
            a = {16'h0, 16'($urandom)};
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            do_req($sformatf("rnd%0d", n), 1'($urandom), f3, a, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
